ping_pong_sequencer: RTL

PING_PONG_SEQUENCER -- requirements
Module: ping_pong_sequencer

---
 rtl/ping_pong_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ping_pong_sequencer.sv
// rtl/ping_pong_sequencer.sv - segment-table sequencer driving an external ping-pong counter
module ping_pong_sequencer #(
    parameter int NSEG = 4,
    parameter int SW   = $clog2(NSEG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [3:0]    wr_min,
    input  logic [3:0]    wr_max,
    input  logic [3:0]    wr_bounces,
    input  logic          flip_req,
    input  logic [3:0]    cnt_out,
    input  logic          cnt_dir,
    output logic          cnt_enable,
    output logic          cnt_flip,
    output logic [3:0]    cnt_min,
    output logic [3:0]    cnt_max,
    output logic          busy,
    output logic [SW-1:0] seg_idx,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [SW-1:0] SEG_LAST = SW'(NSEG - 1);

    state_t        state;
    logic [3:0]    tbl_min [NSEG];
    logic [3:0]    tbl_max [NSEG];
    logic [3:0]    tbl_bnc [NSEG];
    logic          flip_pend;
    logic [3:0]    bcnt;

    logic          fwd0;
    logic [3:0]    ld_min;
    logic [3:0]    ld_max;
    logic [SW-1:0] seg_next;
    logic [3:0]    cur_bnc;
    logic [3:0]    bcnt_inc;
    logic          entry_bad;
    logic          at_turn;
    logic          bounce;

    // A write in the same cycle as start must be visible to the first LOAD.
    assign fwd0      = wr_en && (wr_addr == '0);
    assign ld_min    = fwd0 ? wr_min : tbl_min[0];
    assign ld_max    = fwd0 ? wr_max : tbl_max[0];
    assign seg_next  = seg_idx + SW'(1);
    assign cur_bnc   = tbl_bnc[seg_idx];
    assign bcnt_inc  = bcnt + 4'd1;
    assign entry_bad = (cnt_min >= cnt_max) || (cnt_out < cnt_min) || (cnt_out > cnt_max);

    // The flip is only safe strictly inside the range, so it can never coincide with a turnaround.
    assign cnt_flip  = (state == S_RUN) && flip_pend && (cnt_out > cnt_min) && (cnt_out < cnt_max);
    assign at_turn   = (cnt_out == cnt_max && cnt_dir) || (cnt_out == cnt_min && !cnt_dir);
    assign bounce    = (state == S_RUN) && cnt_enable && !cnt_flip && at_turn;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                tbl_min[i] <= '0;
                tbl_max[i] <= '0;
                tbl_bnc[i] <= '0;
            end
        end else if (state == S_IDLE && wr_en) begin
            tbl_min[wr_addr] <= wr_min;
            tbl_max[wr_addr] <= wr_max;
            tbl_bnc[wr_addr] <= wr_bounces;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt_enable <= 1'b0;
            cnt_min    <= '0;
            cnt_max    <= '0;
            seg_idx    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            flip_pend  <= 1'b0;
            bcnt       <= '0;
        end else begin
            done      <= 1'b0;
            flip_pend <= flip_req | (flip_pend & ~cnt_flip);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err     <= 1'b0;
                        seg_idx <= '0;
                        cnt_min <= ld_min;
                        cnt_max <= ld_max;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bcnt <= '0;
                    if (cur_bnc == 4'd0) begin
                        state <= S_NEXT;
                    end else if (entry_bad) begin
                        err   <= 1'b1;
                        state <= S_NEXT;
                    end else begin
                        cnt_enable <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bounce) begin
                        bcnt <= bcnt_inc;
                        if (bcnt_inc == cur_bnc) begin
                            cnt_enable <= 1'b0;
                            state      <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    flip_pend <= 1'b0;
                    if (seg_idx == SEG_LAST) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        seg_idx <= seg_next;
                        cnt_min <= tbl_min[seg_next];
                        cnt_max <= tbl_max[seg_next];
                        state   <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
